// File: rtl/bench_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bench_pkg
// Brief    : Shared types, constants and LFSR helper for the bench pin driver.
// Revision : 1.0
// ============================================================================
package bench_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSTPH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    // Feedback taps at bits 7,5,4,3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [7:0]  LFSR_INIT = 8'h01;

    localparam int CLK      = 0;
    localparam int RSTN     = 1;
    localparam int STIM_LSB = 2;
    localparam int SEL_LSB  = 5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bench_misr16.sv
`default_nettype none
// ============================================================================
// Module   : bench_misr16
// Brief    : 16-bit MISR compressing one 8-bit sample per enable cycle.
// Revision : 1.0
// ============================================================================
module bench_misr16
    import bench_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [7:0]  i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;
    logic [15:0] w_shift;

    always_comb begin
        w_shift = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= MISR_SEED;
        end else if (i_clear) begin
            r_sig <= MISR_SEED;
        end else if (i_enable) begin
            r_sig <= w_shift ^ {8'h00, i_data};
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/bench_pin_driver.sv
`default_nettype none
// ============================================================================
// Module   : bench_pin_driver
// Brief    : Drives benchmark wrapper input pins and signs its output pins.
// Revision : 1.0
// ============================================================================
module bench_pin_driver
    import bench_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int RST_CYC = 4,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] run_len,
    input  logic             abort,
    output logic [7:0]       pin_out,
    input  logic [7:0]       pin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic             aborted
);

    localparam int HC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RC_W = $clog2(RST_CYC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HC_W-1:0]    r_hcnt;
    logic               r_dclk;
    logic [RC_W-1:0]    r_rcnt;
    logic               r_rstn;
    logic [2:0]         r_stim;
    logic [2:0]         r_sel;
    logic [7:0]         r_lfsr;
    logic [LEN_W-1:0]   r_left;
    logic               r_aborted;

    logic               w_active;
    logic               w_hc_last;
    logic               w_rise;
    logic               w_fall;
    logic               w_abort;
    logic               w_start;
    logic               w_release;
    logic               w_sample;
    logic               w_last;
    logic [7:0]         w_lfsr_nxt;

    always_comb begin
        w_active   = (r_state == RSTPH) || (r_state == RUN);
        w_hc_last  = (r_hcnt == HC_W'(DIV - 1));
        w_rise     = w_active && w_hc_last && !r_dclk;
        w_fall     = w_active && w_hc_last && r_dclk;
        w_abort    = abort && (r_state != IDLE);
        w_start    = start && (r_state == IDLE);
        w_release  = (r_state == RSTPH) && w_fall && (r_rcnt == RC_W'(RST_CYC));
        // Sampling coincides with the DUT falling edge: last cycle of the high phase
        w_sample   = (r_state == RUN) && w_fall && !w_abort;
        w_last     = w_sample && (r_left == LEN_W'(1));
        w_lfsr_nxt = lfsr_next(r_lfsr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = w_active;
        done        = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RSTPH;
                end
            end
            RSTPH: begin
                if (w_release) begin
                    w_state_nxt = (r_left == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt    <= '0;
            r_dclk    <= 1'b0;
            r_rcnt    <= '0;
            r_rstn    <= 1'b0;
            r_stim    <= 3'b000;
            r_sel     <= 3'b000;
            r_lfsr    <= LFSR_INIT;
            r_left    <= '0;
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_hcnt    <= '0;
            r_dclk    <= 1'b0;
            r_rstn    <= 1'b0;
            r_stim    <= 3'b000;
            r_aborted <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hcnt <= '0;
                    r_dclk <= 1'b0;
                    r_rstn <= 1'b0;
                    r_stim <= 3'b000;
                    if (w_start) begin
                        r_sel     <= sel;
                        r_lfsr    <= (seed == 8'h00) ? LFSR_INIT : seed;
                        r_left    <= run_len;
                        r_rcnt    <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                RSTPH, RUN: begin
                    if (w_hc_last) begin
                        r_hcnt <= '0;
                        r_dclk <= ~r_dclk;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                    if (w_rise && (r_state == RSTPH)) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                    if (w_release && (r_left != '0)) begin
                        r_rstn <= 1'b1;
                        r_stim <= r_lfsr[2:0];
                    end
                    if (w_sample) begin
                        r_lfsr <= w_lfsr_nxt;
                        r_left <= r_left - 1'b1;
                        // Final sample re-asserts DUT reset as we enter DONE
                        if (w_last) begin
                            r_rstn <= 1'b0;
                            r_stim <= 3'b000;
                        end else begin
                            r_stim <= w_lfsr_nxt[2:0];
                        end
                    end
                end
                default: begin
                    r_hcnt <= '0;
                    r_dclk <= 1'b0;
                    r_rstn <= 1'b0;
                    r_stim <= 3'b000;
                end
            endcase
        end
    end

    always_comb begin
        pin_out                      = 8'h00;
        pin_out[CLK]                 = r_dclk;
        pin_out[RSTN]                = r_rstn;
        pin_out[STIM_LSB +: 3]       = r_stim;
        pin_out[SEL_LSB +: 3]        = r_sel;
    end

    assign aborted = r_aborted;

    bench_misr16 u_misr (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_start),
        .i_enable (w_sample),
        .i_data   (pin_in),
        .o_sig    (signature)
    );

endmodule
`default_nettype wire

// File: tb/tb_bench_pin_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bench_pin_driver
// Brief    : Directed scoreboard bench for bench_pin_driver with a loopback wrapper.
// Revision : 1.0
// ============================================================================
module tb_bench_pin_driver;

    localparam int DIV     = 2;
    localparam int RST_CYC = 4;
    localparam int LEN_W   = 8;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic [2:0]       sel      = 3'b000;
    logic [7:0]       seed     = 8'h00;
    logic [LEN_W-1:0] run_len  = '0;
    logic [7:0]       pin_out;
    logic [7:0]       pin_in;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [15:0]      signature;
    logic             tie_zero = 1'b1;
    logic [2:0]       exp_sel  = 3'b000;

    // Wrapper stand-in: outputs are a rotation of the pins it receives
    assign pin_in = tie_zero ? 8'h00 : {pin_out[4:2], pin_out[7:5], pin_out[1:0]};

    always #5 clk = ~clk;

    bench_pin_driver #(.DIV(DIV), .RST_CYC(RST_CYC), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel       (sel),
        .seed      (seed),
        .run_len   (run_len),
        .abort     (abort),
        .pin_out   (pin_out),
        .pin_in    (pin_in),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .aborted   (aborted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int n_done = 0, n_busy = 0, n_rst_rise = 0, n_run_rise = 0;
    int n_tgl_bad = 0, n_rstn_hi = 0, n_sel_bad = 0;
    int gap = 0;
    bit seen_tgl = 1'b0;
    logic prev_clk = 1'b0;
    logic [2:0] obs_stim [0:1023];

    always @(negedge clk) begin
        gap = gap + 1;
        if (pin_out[0] !== prev_clk) begin
            if (seen_tgl && gap != DIV) n_tgl_bad = n_tgl_bad + 1;
            gap = 0;
            seen_tgl = 1'b1;
            if (pin_out[0] === 1'b1) begin
                if (pin_out[1] === 1'b1) begin
                    if (n_run_rise < 1024) obs_stim[n_run_rise] = pin_out[4:2];
                    n_run_rise = n_run_rise + 1;
                end else begin
                    n_rst_rise = n_rst_rise + 1;
                end
            end
        end
        if (busy !== 1'b1) seen_tgl = 1'b0;
        prev_clk = pin_out[0];
        if (done === 1'b1) n_done = n_done + 1;
        if (busy === 1'b1) n_busy = n_busy + 1;
        if (pin_out[1] === 1'b1) n_rstn_hi = n_rstn_hi + 1;
        if ((busy === 1'b1 || done === 1'b1) && pin_out[7:5] !== exp_sel) n_sel_bad = n_sel_bad + 1;
    end

    logic [15:0] q_exp_sig [$];
    logic [2:0]  q_exp_stim [$];

    int b_done, b_busy, b_rst, b_run, b_tgl, b_rhi, b_sel;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {8'h00, d};
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_done = n_done; b_busy = n_busy; b_rst = n_rst_rise; b_run = n_run_rise;
        b_tgl = n_tgl_bad; b_rhi = n_rstn_hi; b_sel = n_sel_bad;
    endtask

    // Model the run, queue its expectations, then issue the start pulse
    task automatic launch(input logic [2:0] s, input logic [7:0] sd, input logic [7:0] len,
                          input int nsamp, input bit tie);
        logic [7:0]  lf;
        logic [15:0] sg;
        logic [2:0]  st;
        lf = (sd == 8'h00) ? 8'h01 : sd;
        sg = 16'hFFFF;
        for (int k = 0; k < nsamp; k++) begin
            st = lf[2:0];
            q_exp_stim.push_back(st);
            sg = misr_step(sg, tie ? 8'h00 : {st, s, 2'b11});
            lf = lfsr_step(lf);
        end
        q_exp_sig.push_back(sg);
        snap();
        tie_zero = tie;
        exp_sel  = s;
        sel      = s;
        seed     = sd;
        run_len  = len;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit got;
        got = 1'b0;
        for (int k = 0; k < max_cyc && !got; k++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stims(input int n);
        logic [2:0] e;
        for (int i = 0; i < n; i++) begin
            e = q_exp_stim.pop_front();
            chk("stim", {29'd0, obs_stim[(b_run + i) % 1024]}, {29'd0, e});
        end
    endtask

    task automatic check_sig(input string tag);
        logic [15:0] e;
        e = q_exp_sig.pop_front();
        chk(tag, {16'd0, signature}, {16'd0, e});
    endtask

    initial begin
        int d;
        bit got;
        int cnt;
        logic pc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pin_out",   {24'd0, pin_out}, 32'h00);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_aborted",   {31'd0, aborted}, 32'd0);
        chk("rst_signature", {16'd0, signature}, 32'hFFFF);

        snap();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_pin_out", {24'd0, pin_out}, 32'h00);
        end
        chk("idle_done_count", n_done - b_done, 0);
        chk("idle_busy_count", n_busy - b_busy, 0);
        chk("idle_signature", {16'd0, signature}, 32'hFFFF);

        // Single sample, zero seed, wrapper outputs tied low
        launch(3'b101, 8'h00, 8'd1, 1, 1'b1);
        wait_done(400);
        chk("r1_done_count", n_done - b_done, 1);
        chk("r1_rst_rises", n_rst_rise - b_rst, RST_CYC);
        chk("r1_run_rises", n_run_rise - b_run, 1);
        chk("r1_toggle_gap", n_tgl_bad - b_tgl, 0);
        chk("r1_sel_during", n_sel_bad - b_sel, 0);
        check_stims(1);
        check_sig("r1_signature");
        chk("r1_signature_const", {16'd0, signature}, 32'hEFDF);
        chk("r1_sel_after", {29'd0, pin_out[7:5]}, 32'b101);
        chk("r1_busy_len", n_busy - b_busy, (RST_CYC + 1) * 2 * DIV);

        // Four samples from seed 01 with loopback data
        launch(3'b011, 8'h01, 8'd4, 4, 1'b0);
        wait_done(400);
        d = n_busy - b_busy;
        chk("r2_busy_len_ok", {31'd0, (d >= 30 && d <= 34)}, 32'd1);
        chk("r2_run_rises", n_run_rise - b_run, 4);
        chk("r2_toggle_gap", n_tgl_bad - b_tgl, 0);
        chk("r2_done_count", n_done - b_done, 1);
        check_stims(4);
        check_sig("r2_signature");

        // Zero-length run: reset phase only
        launch(3'b011, 8'h77, 8'd0, 0, 1'b0);
        wait_done(400);
        chk("r3_rstn_high", n_rstn_hi - b_rhi, 0);
        chk("r3_rst_rises", n_rst_rise - b_rst, RST_CYC);
        chk("r3_done_count", n_done - b_done, 1);
        check_sig("r3_signature");

        // Abort during the high phase of the third RUN cycle: two samples taken
        launch(3'b110, 8'h5A, 8'd8, 2, 1'b0);
        got = 1'b0; cnt = 0; pc = pin_out[0];
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (pin_out[1:0] == 2'b11 && pc == 1'b0) cnt++;
            pc = pin_out[0];
            if (cnt == 3) got = 1'b1;
        end
        chk("ab_point_reached", {31'd0, got}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_pins_low", {30'd0, pin_out[1:0]}, 32'd0);
        chk("ab_stim_zero", {29'd0, pin_out[4:2]}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_aborted", {31'd0, aborted}, 32'd1);
        repeat (20) @(negedge clk);
        chk("ab_no_done", n_done - b_done, 0);
        chk("ab_run_rises", n_run_rise - b_run, 3);
        check_stims(2);
        check_sig("ab_partial_sig");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("ab_idle_ignored", {31'd0, aborted}, 32'd1);
        chk("ab_idle_busy", {31'd0, busy}, 32'd0);

        // Restart after abort clears the flag and completes
        launch(3'b001, 8'hC3, 8'd5, 5, 1'b0);
        chk("re_aborted_clr", {31'd0, aborted}, 32'd0);
        chk("re_busy", {31'd0, busy}, 32'd1);
        wait_done(400);
        chk("re_done_count", n_done - b_done, 1);
        check_stims(5);
        check_sig("re_signature");

        // Start while busy must be ignored
        launch(3'b010, 8'h33, 8'd3, 3, 1'b0);
        repeat (5) @(negedge clk);
        sel = 3'b111; run_len = 8'd9; seed = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        chk("sb_run_rises", n_run_rise - b_run, 3);
        chk("sb_busy_len", n_busy - b_busy, (RST_CYC + 3) * 2 * DIV);
        chk("sb_sel_during", n_sel_bad - b_sel, 0);
        chk("sb_sel_after", {29'd0, pin_out[7:5]}, 32'b010);
        check_stims(3);
        check_sig("sb_signature");

        // Reset in the middle of RUN
        tie_zero = 1'b0; exp_sel = 3'b100;
        sel = 3'b100; seed = 8'h9C; run_len = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_pin_out", {24'd0, pin_out}, 32'h00);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_signature", {16'd0, signature}, 32'hFFFF);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
